// File: rtl/timer_apb_sequencer.sv
`default_nettype none
// ============================================================================
// timer_apb_sequencer : APB master that loads, runs, polls and stops the timer
// Rev 1.0
// ============================================================================
module timer_apb_sequencer #(
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned PREADY_TO = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cfg_tdr,
  input  logic       cfg_down,
  input  logic [1:0] cfg_cks,
  input  logic [7:0] cfg_periods,
  output logic       busy,
  output logic       period_pulse,
  output logic       done,
  output logic       err,
  output logic [7:0] paddr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WR_TDR  = 3'd1;
  localparam logic [2:0] c_WR_LOAD = 3'd2;
  localparam logic [2:0] c_WR_RUN  = 3'd3;
  localparam logic [2:0] c_GAP     = 3'd4;
  localparam logic [2:0] c_RD_TSR  = 3'd5;
  localparam logic [2:0] c_CLR_TSR = 3'd6;
  localparam logic [2:0] c_WR_STOP = 3'd7;

  // HOLD is the dead cycle with psel low that follows an aborted transfer
  localparam logic [1:0] c_PH_SETUP  = 2'd0;
  localparam logic [1:0] c_PH_ACCESS = 2'd1;
  localparam logic [1:0] c_PH_HOLD   = 2'd2;

  localparam int unsigned c_GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam int unsigned c_GW       = (c_GAP_LAST > 0) ? $clog2(c_GAP_LAST + 1) : 1;
  localparam int unsigned c_TO_LAST  = (PREADY_TO > 0) ? PREADY_TO - 1 : 0;
  localparam int unsigned c_TW       = (c_TO_LAST > 0) ? $clog2(c_TO_LAST + 1) : 1;
  localparam logic [2:0]  c_GAP_NEXT = (POLL_GAP == 0) ? c_RD_TSR : c_GAP;

  logic [2:0]      r_state, w_state_nxt;
  logic [1:0]      r_ph, w_ph_nxt;
  logic [c_GW-1:0] r_gap;
  logic [c_TW-1:0] r_wait;
  logic [7:0]      r_count, r_tdr, r_periods;
  logic [1:0]      r_cks;
  logic            r_down, r_stop_req, r_err, r_pulse, r_done;

  logic       w_xfer, w_access, w_timeout, w_ok, w_fail, w_flag, w_stop, w_last;
  logic [7:0] w_count_inc, w_flag_mask;

  assign w_xfer      = (r_state != c_IDLE) && (r_state != c_GAP);
  assign w_access    = w_xfer && (r_ph == c_PH_ACCESS);
  assign w_timeout   = w_access && !pready && (r_wait == c_TW'(c_TO_LAST));
  assign w_fail      = w_access && ((pready && pslverr) || w_timeout);
  assign w_ok        = w_access && pready && !pslverr;
  assign w_flag_mask = r_down ? 8'h02 : 8'h01;
  assign w_flag      = |(prdata & w_flag_mask);
  assign w_stop      = r_stop_req || stop;
  assign w_count_inc = r_count + 8'd1;
  assign w_last      = (r_periods != 8'd0) && (w_count_inc == r_periods);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= c_IDLE;
      r_ph    <= c_PH_SETUP;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_state_nxt = c_WR_TDR;
          w_ph_nxt    = c_PH_SETUP;
        end
      end
      c_GAP: begin
        w_ph_nxt = c_PH_SETUP;
        if (w_stop)
          w_state_nxt = c_WR_STOP;
        else if (r_gap == c_GW'(c_GAP_LAST))
          w_state_nxt = c_RD_TSR;
      end
      default: begin
        if (r_ph == c_PH_ACCESS) begin
          if (w_fail) begin
            w_ph_nxt    = c_PH_HOLD;
            w_state_nxt = (r_state == c_WR_STOP) ? c_IDLE : c_WR_STOP;
          end else if (w_ok) begin
            w_ph_nxt = c_PH_SETUP;
            case (r_state)
              c_WR_TDR:  w_state_nxt = w_stop ? c_WR_STOP : c_WR_LOAD;
              c_WR_LOAD: w_state_nxt = w_stop ? c_WR_STOP : c_WR_RUN;
              c_WR_RUN:  w_state_nxt = w_stop ? c_WR_STOP : c_GAP_NEXT;
              // a set flag is always cleared and counted, even with stop pending
              c_RD_TSR:  w_state_nxt = w_flag ? c_CLR_TSR : (w_stop ? c_WR_STOP : c_GAP_NEXT);
              c_CLR_TSR: w_state_nxt = (w_stop || w_last) ? c_WR_STOP : c_GAP_NEXT;
              default:   w_state_nxt = c_IDLE;
            endcase
          end
        end else if (r_ph == c_PH_SETUP) begin
          w_ph_nxt = c_PH_ACCESS;
        end else begin
          w_ph_nxt = c_PH_SETUP;
        end
      end
    endcase
  end

  always_comb begin
    paddr   = 8'h00;
    pwdata  = 8'h00;
    pwrite  = 1'b0;
    psel    = w_xfer && (r_ph != c_PH_HOLD);
    penable = w_access;
    case (r_state)
      c_WR_TDR:  begin paddr = 8'h00; pwrite = 1'b1; pwdata = r_tdr; end
      c_WR_LOAD: begin paddr = 8'h01; pwrite = 1'b1; pwdata = {3'b100, r_down, 2'b00, r_cks}; end
      c_WR_RUN:  begin paddr = 8'h01; pwrite = 1'b1; pwdata = {3'b001, r_down, 2'b00, r_cks}; end
      c_RD_TSR:  begin paddr = 8'h02; pwrite = 1'b0; end
      c_CLR_TSR: begin paddr = 8'h02; pwrite = 1'b1; end
      c_WR_STOP: begin paddr = 8'h01; pwrite = 1'b1; end
      default:   begin paddr = 8'h00; end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_gap      <= '0;
      r_wait     <= '0;
      r_count    <= 8'h00;
      r_tdr      <= 8'h00;
      r_periods  <= 8'h00;
      r_cks      <= 2'b00;
      r_down     <= 1'b0;
      r_stop_req <= 1'b0;
      r_err      <= 1'b0;
      r_pulse    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_gap   <= (r_state == c_GAP) ? r_gap + c_GW'(1) : '0;
      r_wait  <= (w_access && !pready) ? r_wait + c_TW'(1) : '0;
      r_pulse <= w_ok && (r_state == c_CLR_TSR);
      r_done  <= w_ok && (r_state == c_WR_STOP) && !r_err;
      if ((r_state == c_IDLE) && start) begin
        r_tdr      <= cfg_tdr;
        r_down     <= cfg_down;
        r_cks      <= cfg_cks;
        r_periods  <= cfg_periods;
        r_count    <= 8'h00;
        r_err      <= 1'b0;
        r_stop_req <= 1'b0;
      end else begin
        if (w_fail)
          r_err <= 1'b1;
        if (w_ok && (r_state == c_CLR_TSR))
          r_count <= w_count_inc;
        if (stop && (r_state != c_IDLE) && (r_state != c_WR_STOP))
          r_stop_req <= 1'b1;
      end
    end
  end

  assign busy         = (r_state != c_IDLE);
  assign period_pulse = r_pulse;
  assign done         = r_done;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_sequencer.sv
`default_nettype none
// Bench for timer_apb_sequencer: APB slave model records completed transfers,
// each scenario queues the transfers it expects and compares them in order.
module tb_timer_apb_sequencer;

  localparam int c_POLL_GAP  = 4;
  localparam int c_PREADY_TO = 16;

  typedef struct packed {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] data;
  } xfer_t;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_tdr = 8'h00;
  logic       cfg_down = 1'b0;
  logic [1:0] cfg_cks = 2'b00;
  logic [7:0] cfg_periods = 8'h00;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b1;
  logic       pslverr = 1'b0;
  logic       busy, period_pulse, done, err, psel, penable, pwrite;
  logic [7:0] paddr, pwdata;

  xfer_t      exp_q[$];
  xfer_t      obs_q[$];
  logic [7:0] tsr_q[$];
  int         total = 0;
  int         bad = 0;
  int         pulse_cnt = 0;
  int         done_cnt = 0;

  bit         stall_en = 1'b0;
  logic [7:0] stall_addr = 8'h00;
  bit         stall_use_data = 1'b0;
  logic [7:0] stall_data = 8'h00;
  bit         slverr_en = 1'b0;
  logic [7:0] slverr_addr = 8'h00;
  logic [7:0] mon_rd;

  timer_apb_sequencer #(
    .POLL_GAP (c_POLL_GAP),
    .PREADY_TO(c_PREADY_TO)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .start       (start),
    .stop        (stop),
    .cfg_tdr     (cfg_tdr),
    .cfg_down    (cfg_down),
    .cfg_cks     (cfg_cks),
    .cfg_periods (cfg_periods),
    .busy        (busy),
    .period_pulse(period_pulse),
    .done        (done),
    .err         (err),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  // Slave response for the coming edge plus capture of completing transfers
  always @(negedge pclk) begin
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = 8'h00;
    if (psel && penable) begin
      if (stall_en && (paddr == stall_addr) && (!stall_use_data || (pwdata == stall_data)))
        pready = 1'b0;
      if (slverr_en && (paddr == slverr_addr))
        pslverr = 1'b1;
      mon_rd = 8'h00;
      if (!pwrite && pready && (paddr == 8'h02) && (tsr_q.size() > 0))
        mon_rd = tsr_q.pop_front();
      prdata = mon_rd;
      if (pready)
        obs_q.push_back(xfer_t'({paddr, pwrite, pwrite ? pwdata : mon_rd}));
    end
    if (period_pulse) pulse_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_x(input logic [7:0] a, input logic w, input logic [7:0] d);
    exp_q.push_back(xfer_t'({a, w, d}));
  endtask

  task automatic new_scenario();
    exp_q.delete();
    obs_q.delete();
    tsr_q.delete();
    pulse_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic do_start(input logic [7:0] tdr, input logic down, input logic [1:0] cks,
                          input logic [7:0] per);
    @(negedge pclk); #1;
    cfg_tdr = tdr; cfg_down = down; cfg_cks = cks; cfg_periods = per;
    start = 1'b1;
    @(negedge pclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge pclk);
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL rst_ctl: got %b want 000", {psel, penable, pwrite}); end
    total++; if (paddr !== 8'h00) begin bad++; $display("FAIL rst_paddr: got %h want 00", paddr); end
    total++; if (pwdata !== 8'h00) begin bad++; $display("FAIL rst_pwdata: got %h want 00", pwdata); end
    total++; if ({period_pulse, done, err} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {period_pulse, done, err}); end
    presetn = 1'b1;
  endtask

  task automatic test_count_up();
    xfer_t e, o;
    bit ok;
    new_scenario();
    tsr_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
    expect_x(8'h00, 1'b1, 8'hFD); expect_x(8'h01, 1'b1, 8'h80); expect_x(8'h01, 1'b1, 8'h20);
    expect_x(8'h02, 1'b0, 8'h00); expect_x(8'h02, 1'b0, 8'h01); expect_x(8'h02, 1'b1, 8'h00);
    expect_x(8'h02, 1'b0, 8'h00); expect_x(8'h02, 1'b0, 8'h00); expect_x(8'h02, 1'b0, 8'h01);
    expect_x(8'h02, 1'b1, 8'h00); expect_x(8'h01, 1'b1, 8'h00);
    do_start(8'hFD, 1'b0, 2'd0, 8'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_busy: got %b want 1", busy); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL up_idle: got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL up_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL up_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL up_extra: got %0d extra want 0", obs_q.size()); end
    total++; if (pulse_cnt != 2) begin bad++; $display("FAIL up_pulses: got %0d want 2", pulse_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL up_done: got %0d want 1", done_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL up_err: got %b want 0", err); end
  endtask

  task automatic test_count_down();
    xfer_t e, o;
    bit ok;
    new_scenario();
    tsr_q = '{8'h01, 8'h02};
    expect_x(8'h00, 1'b1, 8'h02); expect_x(8'h01, 1'b1, 8'h90); expect_x(8'h01, 1'b1, 8'h30);
    expect_x(8'h02, 1'b0, 8'h01); expect_x(8'h02, 1'b0, 8'h02); expect_x(8'h02, 1'b1, 8'h00);
    expect_x(8'h01, 1'b1, 8'h00);
    do_start(8'h02, 1'b1, 2'd0, 8'd1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL dn_idle: got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL dn_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL dn_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL dn_extra: got %0d extra want 0", obs_q.size()); end
    total++; if (pulse_cnt != 1) begin bad++; $display("FAIL dn_pulses: got %0d want 1", pulse_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL dn_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_continuous_stop();
    xfer_t e, o;
    bit ok;
    new_scenario();
    tsr_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    expect_x(8'h00, 1'b1, 8'h10); expect_x(8'h01, 1'b1, 8'h83); expect_x(8'h01, 1'b1, 8'h23);
    for (int i = 0; i < 5; i++) begin
      expect_x(8'h02, 1'b0, 8'h01);
      expect_x(8'h02, 1'b1, 8'h00);
    end
    expect_x(8'h01, 1'b1, 8'h00);
    do_start(8'h10, 1'b0, 2'd3, 8'd0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge pclk); #1;
      if (pulse_cnt == 5) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL cont_pulse5: got %0d pulses want 5", pulse_cnt); end
    total++; if ({busy, psel} !== 2'b10) begin bad++; $display("FAIL cont_in_gap: got busy,psel=%b want 10", {busy, psel}); end
    stop = 1'b1;
    @(negedge pclk); #1;
    stop = 1'b0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_idle: got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL cont_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL cont_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL cont_extra: got %0d extra want 0", obs_q.size()); end
    total++; if (pulse_cnt != 5) begin bad++; $display("FAIL cont_pulses: got %0d want 5", pulse_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL cont_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_timeout();
    xfer_t e, o;
    bit ok;
    int k;
    new_scenario();
    stall_en = 1'b1; stall_addr = 8'h01; stall_use_data = 1'b1; stall_data = 8'h80;
    expect_x(8'h00, 1'b1, 8'h55); expect_x(8'h01, 1'b1, 8'h00);
    do_start(8'h55, 1'b0, 2'd0, 8'd3);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (psel && penable && (paddr == 8'h01) && (pwdata == 8'h80)) begin ok = 1'b1; break; end
      @(negedge pclk); #1;
    end
    total++; if (!ok) begin bad++; $display("FAIL to_access: got no WR_LOAD access want one"); end
    k = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk); #1;
      if (psel && penable && (paddr == 8'h01) && (pwdata == 8'h80)) k++;
      else break;
    end
    total++; if (k != c_PREADY_TO) begin bad++; $display("FAIL to_cycles: got %0d want %0d", k, c_PREADY_TO); end
    total++; if (psel !== 1'b0) begin bad++; $display("FAIL to_psel_drop: got %b want 0", psel); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_idle: got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL to_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL to_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL to_extra: got %0d extra want 0", obs_q.size()); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL to_done: got %0d want 0", done_cnt); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", err); end
    stall_en = 1'b0; stall_use_data = 1'b0;
  endtask

  task automatic test_slverr();
    xfer_t e, o;
    bit ok;
    new_scenario();
    slverr_en = 1'b1; slverr_addr = 8'h00;
    expect_x(8'h00, 1'b1, 8'h33); expect_x(8'h01, 1'b1, 8'h00);
    do_start(8'h33, 1'b0, 2'd1, 8'd2);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL se_err_clear: got %b want 0", err); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL se_idle: got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL se_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL se_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL se_extra: got %0d extra want 0", obs_q.size()); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL se_err: got %b want 1", err); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL se_done: got %0d want 0", done_cnt); end
    slverr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    xfer_t e, o;
    bit ok;
    new_scenario();
    stall_en = 1'b1; stall_addr = 8'h02; stall_use_data = 1'b0;
    expect_x(8'h00, 1'b1, 8'h40); expect_x(8'h01, 1'b1, 8'h82); expect_x(8'h01, 1'b1, 8'h22);
    do_start(8'h40, 1'b0, 2'd2, 8'd0);
    cfg_tdr = 8'hEE; start = 1'b1;
    @(negedge pclk); #1;
    start = 1'b0; cfg_tdr = 8'h40;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk); #1;
      if (psel && penable && (paddr == 8'h02)) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rm_rd_access: got none want TSR access"); end
    presetn = 1'b0;
    @(negedge pclk); #1;
    total++; if ({psel, penable} !== 2'b00) begin bad++; $display("FAIL rm_apb_drop: got %b want 00", {psel, penable}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge pclk); #1;
    presetn = 1'b1;
    stall_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rm_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rm_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rm_extra: got %0d extra want 0", obs_q.size()); end
    new_scenario();
    tsr_q = '{8'h02};
    expect_x(8'h00, 1'b1, 8'h41); expect_x(8'h01, 1'b1, 8'h91); expect_x(8'h01, 1'b1, 8'h31);
    expect_x(8'h02, 1'b0, 8'h02); expect_x(8'h02, 1'b1, 8'h00); expect_x(8'h01, 1'b1, 8'h00);
    do_start(8'h41, 1'b1, 2'd1, 8'd1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL rm2_idle: got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin bad++; $display("FAIL rm2_xfer: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rm2_xfer: got %h want %h", o, e); end end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rm2_extra: got %0d extra want 0", obs_q.size()); end
    total++; if (pulse_cnt != 1) begin bad++; $display("FAIL rm2_pulses: got %0d want 1", pulse_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rm2_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_continuous_stop();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_apb_sequencer.md
Name: timer_apb_sequencer

Overview:
- APB master controller that configures and runs the 8-bit timer slave (TDR 0x00, TCR 0x01, TSR 0x02) without CPU involvement.
- On a start command it:
  - loads TDR, then pulses the TCR load bit, then enables counting;
  - polls TSR for the overflow or underflow flag and clears it each period;
  - stops the timer after a programmed number of periods, or on request.
- It sits between local control logic and the timer's APB slave port, in place of the CPU bus functional model.

Parameters:
- POLL_GAP, 4, idle cycles between consecutive TSR reads (0 = back-to-back).
- PREADY_TO, 16, maximum ACCESS-phase cycles waiting for pready before timeout.

Ports:
- pclk  in  1  APB clock, sole clock
- presetn  in  1  synchronous reset, active-low
- start  in  1  single-cycle start request; sampled only in IDLE
- stop  in  1  single-cycle stop request; honoured at the next transfer boundary
- cfg_tdr  in  8  TDR preload value
- cfg_down  in  1  0 = count up (watch OVF), 1 = count down (watch UDF)
- cfg_cks  in  2  clock-select field written to TCR[1:0]
- cfg_periods  in  8  periods to run; 0 = continuous until stop
- busy  out  1  high from start acceptance until return to IDLE
- period_pulse  out  1  one-cycle pulse per detected and cleared flag
- done  out  1  one-cycle pulse when the stop write completes normally
- err  out  1  sticky; set on pslverr or timeout; cleared on next accepted start
- paddr  out  8  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  8  APB write data
- prdata  in  8  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset (presetn=0 at a pclk edge) forces all of the following on that edge, including mid-transfer with no completion wait:
  - state IDLE;
  - busy, period_pulse, done, err, psel, penable, pwrite = 0;
  - paddr, pwdata = 0x00;
  - period counter = 0.
- start/stop acceptance:
  - In IDLE, start=1 latches cfg_* and sets busy next cycle.
  - start while busy is ignored.
- TCR encoding:
  - bit7 = load, bit5 = enable, bit4 = cfg_down, bits1:0 = cfg_cks; other bits 0.
  - Flag bit in TSR: bit0 = OVF (up), bit1 = UDF (down).
- APB transfer, every access:
  - SETUP: one cycle, psel=1, penable=0, with paddr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - Address, data and direction are stable across both phases.
  - psel and penable drop in the cycle after completion, unless the next transfer begins immediately in SETUP.
- State sequence:
  - IDLE -> WR_TDR (0x00 <= cfg_tdr)
  - WR_TDR -> WR_LOAD (0x01 <= 0x80|dir|cks)
  - WR_LOAD -> WR_RUN (0x01 <= 0x20|dir|cks)
  - WR_RUN -> GAP
  - GAP -> RD_TSR after POLL_GAP cycles.
- RD_TSR, on completion, samples prdata:
  - If the selected flag bit is clear -> GAP.
  - If it is set -> CLR_TSR (0x02 <= 0x00). The non-selected flag is ignored.
- CLR_TSR completion:
  - period_pulse=1 for one cycle; counter increments, 8-bit, wraps 255->0.
  - If cfg_periods != 0 and the new count == cfg_periods -> WR_STOP (0x01 <= 0x00).
  - Otherwise -> GAP.
- WR_STOP completion: done=1 for one cycle (only if no error occurred), busy=0 -> IDLE.
- stop handling:
  - stop=1 while busy is latched.
  - It takes effect when the current transfer completes, or immediately if in GAP; the next state is WR_STOP.
  - A flag read that completes in the same cycle stop is latched still goes through CLR_TSR first; that period counts and pulses.
  - stop during WR_STOP, and stop in IDLE, are ignored.
- Errors (pslverr=1 with pready=1, or timeout):
  - Timeout = PREADY_TO ACCESS cycles with pready=0.
  - On error, err is set and the transfer terminates (psel=0 next cycle).
  - Error on any transfer other than WR_STOP -> WR_STOP.
  - Error on WR_STOP -> IDLE, no done.
  - Whenever err is set, done is suppressed.
- cfg_periods=1 stops after the first flag. Counter reset to 0 on each accepted start.

Test Plan:
- cfg_tdr=0xFD, cfg_down=0, cfg_cks=0, cfg_periods=2, pready tied 1 -> writes seen in order:
  - 0x00<=0xFD, 0x01<=0x80, 0x01<=0x20;
  - TSR reads; after TSR returns 0x01, write 0x02<=0x00;
  - period_pulse twice, then 0x01<=0x00, done=1 once, busy=0.
- cfg_down=1, cfg_tdr=0x02, cfg_periods=1; slave returns TSR=0x01 then 0x02:
  - 0x01 is ignored, only 0x02 triggers clear;
  - TCR writes 0x90 then 0x30; single period_pulse, done.
- cfg_periods=0, run 5 flags, then pulse stop during GAP -> 5 period_pulses, next transfer is 0x01<=0x00, done=1.
- pready held 0 during WR_LOAD for PREADY_TO cycles:
  - err=1, psel drops;
  - next transfer 0x01<=0x00 completes; done stays 0; err holds until next start.
- pslverr=1 on WR_TDR -> err=1, WR_STOP issued, no WR_LOAD/WR_RUN writes.
- presetn=0 in the ACCESS phase of RD_TSR:
  - next edge psel=penable=0, busy=0;
  - start pulsed while busy is ignored;
  - after release, a new start replays the full sequence from WR_TDR.
